// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//
// UART receiver for 8 data bits, no parity and 1 stop bit, sent LSB first.
// It turns the asynchronous `rx` line into bytes. Each finished byte waits in
// a one-entry output register that uses a valid/ready handshake.
//
// Ports:
//   clk        system clock (single clock domain)
//   rst        synchronous, active-high reset
//   rx         asynchronous serial input, idles high
//   out_data   received byte, stable while out_valid is high
//   out_valid  a byte is waiting; held until the consumer takes it
//   out_ready  consumer takes the byte on an edge where valid and ready are both 1
//   frame_err  one-cycle pulse when a stop bit samples low
//   overrun    one-cycle pulse when a finished byte is dropped because the
//              output register is still full
//   busy       high whenever the receiver is not idle
module uart_byte_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_baud
        $error("uart_byte_rx: CLK_FREQ/BAUD must be at least 8");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;

    logic             rx_meta, rx_s, rx_prev;
    logic [1:0]       settle;
    logic             armed;
    logic             start_edge;
    logic             deliver;
    logic             stop_bad;

    assign start_edge = armed && rx_prev && !rx_s;
    assign busy       = (state != IDLE);

    // Synchronizer, edge-detect history and the arm bit.
    // The synchronizer flops reset to 1. During the first two cycles after
    // reset, rx_s shows those reset values and not the real line level.
    // `settle` waits until real line samples reach rx_s. Because of this, a
    // line held low through reset release never arms the receiver.
    // After a framing error the arm bit is cleared. The line must then go
    // high again before another start bit is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            settle  <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            settle  <= {settle[0], 1'b1};
            if (stop_bad) begin
                armed <= 1'b0;
            end else if (settle[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Register for the FSM state, the bit-period counter and the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    // Next-state logic.
    // The start bit is sampled at mid-bit. Each later bit is sampled one full
    // bit period after the previous sample, so every sample lands near the
    // middle of its bit.
    // The FSM leaves STOP at the stop-bit sample, half a bit early. This lets
    // it catch a start edge that follows right after the stop bit.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        deliver   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start_edge) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        bit_idx_n = 3'd0;
                        state_n   = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        deliver = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // One-entry output register and the status flag pulses.
    // If a new byte arrives on the same edge the old byte is consumed, the new
    // byte replaces it. If the old byte is still waiting, the new byte is
    // dropped and an overrun is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= deliver && out_valid && !out_ready;
            if (deliver && (!out_valid || out_ready)) begin
                out_data  <= shift;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx
//
// Directed bench for uart_byte_rx. The receiver runs with 16 clocks per bit
// so each frame is short. A negedge monitor keeps running totals of new
// output bytes, flag pulses and busy cycles. Each step compares the change
// in those totals against hand-computed values.
module tb_uart_byte_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int N        = 16;            // CLK_FREQ / BAUD
    localparam int HALF     = N / 2;
    localparam int BIT_T    = N * 10;        // clock period is 10 time units
    // pin fall -> 2 synchronizer edges -> edge-detect cycle -> START edge,
    // then HALF + 9*N edges to the stop sample, output visible next cycle
    localparam int LATENCY  = 3 + HALF + 9 * N;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int n_new = 0;
    int n_valid_cyc = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_busy = 0;
    logic [7:0] byte_log[$];
    logic prev_valid = 1'b0;
    logic prev_take = 1'b0;

    int s_new, s_vc, s_ferr, s_ovr, s_busy;

    uart_byte_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A byte is new when out_valid rises. It is also new when out_valid stays
    // high right after a consume.
    always @(negedge clk) begin
        if (out_valid && (!prev_valid || prev_take)) begin
            byte_log.push_back(out_data);
            rise_cyc = cyc;
            n_new++;
        end
        if (out_valid) n_valid_cyc++;
        if (frame_err) n_ferr++;
        if (overrun)   n_ovr++;
        if (busy)      n_busy++;
        prev_valid = out_valid;
        prev_take  = out_valid && out_ready;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                  input int bit_t);
        @(posedge clk);
        #2;
        fall_cyc = cyc;
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(bit_t);
        end
        rx = stop_bit;
        #(bit_t);
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b0;
    endtask

    function automatic logic [31:0] logged(input int idx);
        return (byte_log.size() > idx) ? {24'h0, byte_log[idx]} : 32'hDEAD;
    endfunction

    initial begin
        rst       = 1'b1;
        rx        = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset values");
        check_output("rst_out_data",  out_data,  8'h00);
        check_output("rst_out_valid", out_valid, 1'b0);
        check_output("rst_frame_err", frame_err, 1'b0);
        check_output("rst_overrun",   overrun,   1'b0);
        check_output("rst_busy",      busy,      1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] single byte 0xCC");
        s_new = n_new;
        apply_stimulus(8'hCC, 1'b1, BIT_T);
        repeat (4) @(negedge clk);
        check_output("cc_count",   n_new - s_new, 1);
        check_output("cc_logged",  logged(s_new), 8'hCC);
        check_output("cc_latency", rise_cyc - fall_cyc, LATENCY);
        check_output("cc_valid",   out_valid, 1'b1);
        check_output("cc_data",    out_data, 8'hCC);
        repeat (20) @(negedge clk);
        check_output("cc_hold_valid", out_valid, 1'b1);
        check_output("cc_hold_data",  out_data, 8'hCC);
        pulse_ready();
        @(negedge clk);
        check_output("cc_consumed", out_valid, 1'b0);

        $display("[TB] back-to-back 0xAA 0x55 with ready held");
        @(posedge clk);
        #2 out_ready = 1'b1;
        s_new = n_new; s_vc = n_valid_cyc; s_ferr = n_ferr; s_ovr = n_ovr;
        apply_stimulus(8'hAA, 1'b1, BIT_T);
        apply_stimulus(8'h55, 1'b1, BIT_T);
        repeat (4) @(negedge clk);
        check_output("b2b_count",      n_new - s_new, 2);
        check_output("b2b_first",      logged(s_new), 8'hAA);
        check_output("b2b_second",     logged(s_new + 1), 8'h55);
        check_output("b2b_valid_cyc",  n_valid_cyc - s_vc, 2);
        check_output("b2b_frame_err",  n_ferr - s_ferr, 0);
        check_output("b2b_overrun",    n_ovr - s_ovr, 0);
        @(posedge clk);
        #2 out_ready = 1'b0;

        $display("[TB] glitch rejection");
        s_new = n_new; s_ferr = n_ferr; s_busy = n_busy;
        @(posedge clk);
        #2 rx = 1'b0;
        #30 rx = 1'b1;
        repeat (30) @(negedge clk);
        check_output("glitch_busy_cyc", n_busy - s_busy, HALF);
        check_output("glitch_no_byte",  n_new - s_new, 0);
        check_output("glitch_no_ferr",  n_ferr - s_ferr, 0);

        $display("[TB] framing error then recovery");
        s_new = n_new; s_ferr = n_ferr;
        apply_stimulus(8'h3C, 1'b0, BIT_T);
        repeat (4) @(negedge clk);
        check_output("ferr_pulses",  n_ferr - s_ferr, 1);
        check_output("ferr_no_byte", n_new - s_new, 0);
        check_output("ferr_valid",   out_valid, 1'b0);
        s_busy = n_busy;
        repeat (40) @(negedge clk);
        check_output("ferr_no_rearm_low", n_busy - s_busy, 0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        s_new = n_new; s_ovr = n_ovr;
        apply_stimulus(8'h81, 1'b1, BIT_T + 3);
        repeat (4) @(negedge clk);
        check_output("recover_count", n_new - s_new, 1);
        check_output("recover_data",  out_data, 8'h81);
        check_output("recover_ovr",   n_ovr - s_ovr, 0);
        pulse_ready();

        $display("[TB] overrun");
        s_new = n_new; s_ovr = n_ovr;
        apply_stimulus(8'h12, 1'b1, BIT_T);
        apply_stimulus(8'h34, 1'b1, BIT_T);
        repeat (4) @(negedge clk);
        check_output("ovr_pulses", n_ovr - s_ovr, 1);
        check_output("ovr_count",  n_new - s_new, 1);
        check_output("ovr_data",   out_data, 8'h12);
        check_output("ovr_valid",  out_valid, 1'b1);

        $display("[TB] reset during DATA of 0xFF");
        s_new = n_new; s_ferr = n_ferr; s_ovr = n_ovr;
        @(posedge clk);
        #2 rx = 1'b0;
        #(BIT_T) rx = 1'b1;
        #(3 * BIT_T);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_output("mid_rst_valid", out_valid, 1'b0);
        check_output("mid_rst_data",  out_data, 8'h00);
        check_output("mid_rst_busy",  busy, 1'b0);
        check_output("mid_rst_ferr",  frame_err, 1'b0);
        check_output("mid_rst_ovr",   overrun, 1'b0);
        repeat (8 * N) @(negedge clk);
        check_output("mid_rst_no_byte", n_new - s_new, 0);
        check_output("mid_rst_no_ferr", n_ferr - s_ferr, 0);
        check_output("mid_rst_no_ovr",  n_ovr - s_ovr, 0);

        $display("[TB] rx held low through reset release");
        rx = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        s_busy = n_busy;
        repeat (40) @(negedge clk);
        check_output("low_rst_no_start", n_busy - s_busy, 0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        s_new = n_new;
        apply_stimulus(8'h5A, 1'b1, BIT_T);
        repeat (4) @(negedge clk);
        check_output("low_rst_count", n_new - s_new, 1);
        check_output("low_rst_data",  out_data, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
